// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rv_mem_pkg
// Brief  : Shared RV32I data-memory encodings, LSU state type and helpers.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package rv_mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_B    = 2'b01;
  localparam logic [1:0] WEN_H    = 2'b10;
  localparam logic [1:0] WEN_W    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ERR   = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Legal width code and natural alignment for that width.
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return (addr_lo[0] == 1'b0);
      F3_W:        return (addr_lo == 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Store width follows funct3[1:0], so the unsigned codes map onto B/H.
  function automatic logic [1:0] wen_for(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return WEN_B;
      2'b01:   return WEN_H;
      default: return WEN_W;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : load_extender
// Brief  : Sign/zero extension of a little-endian load word by RV32I funct3.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module load_extender
  import rv_mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   data = {24'd0, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   data = {16'd0, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dmem_lsu_initiator
// Brief  : Single-outstanding load/store initiator for the data-memory port.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_lsu_initiator
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ren,
  input  logic            dmem_rvalid,
  output logic [1:0]      dmem_wen,
  output logic [XLEN-1:0] dmem_wdata
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT);

  lsu_state_t         r_state;
  logic [2:0]         r_funct3;
  logic [c_cnt_w-1:0] r_cnt;
  logic [XLEN-1:0]    w_ext;
  logic               w_accept;
  logic               w_cnt_last;

  load_extender u_load_extender (
    .funct3 (r_funct3),
    .rdata  (dmem_rdata),
    .data   (w_ext)
  );

  assign w_accept   = req_valid && req_ready && (r_state == ST_IDLE);
  assign w_cnt_last = (r_cnt == c_cnt_w'(TIMEOUT - 1));

  // Every output is a flop; response and write strobes default low each cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_funct3   <= 3'b000;
      r_cnt      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dmem_addr  <= '0;
      dmem_ren   <= 1'b0;
      dmem_wen   <= WEN_NONE;
      dmem_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      dmem_wen   <= WEN_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3   <= req_funct3;
            dmem_addr  <= req_addr;
            dmem_wdata <= req_wdata;
            r_cnt      <= '0;
            req_ready  <= 1'b0;
            if (!access_ok(req_funct3, req_addr[1:0])) begin
              r_state    <= ST_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_store) begin
              r_state  <= ST_STORE;
              dmem_wen <= wen_for(req_funct3);
            end else begin
              r_state  <= ST_LOAD;
              dmem_ren <= 1'b1;
            end
          end
        end
        ST_STORE: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_LOAD: begin
          // Data arriving on the last watchdog cycle still completes normally.
          if (dmem_rvalid) begin
            dmem_ren   <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= w_ext;
            r_state    <= ST_RESP;
          end else if (w_cnt_last) begin
            dmem_ren   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            r_state    <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ERR, ST_RESP: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
          dmem_ren  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_dmem_lsu_initiator
// Brief  : Randomized scoreboard bench with a latency-programmable memory model.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dmem_lsu_initiator;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_addr, dmem_rdata, dmem_wdata;
  logic        dmem_ren, dmem_rvalid;
  logic [1:0]  dmem_wen;

  always #5 clock = ~clock;

  dmem_lsu_initiator #(.TIMEOUT(TIMEOUT), .XLEN(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dmem_addr   (dmem_addr),
    .dmem_rdata  (dmem_rdata),
    .dmem_ren    (dmem_ren),
    .dmem_rvalid (dmem_rvalid),
    .dmem_wen    (dmem_wen),
    .dmem_wdata  (dmem_wdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [1:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } store_t;

  resp_t       rq[$];
  store_t      sq[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mem_lat = NEVER;
  logic [31:0] mem_word = '0;
  int          exp_loads = 0;
  int          seen_loads = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference extension from value ranges rather than bit replication.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] w);
    longint v;
    case (f3)
      3'd0: begin v = w % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = w % 256;
      3'd1: begin v = w % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = w % 65536;
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic bit is_err(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    size = 1 << f3[1:0];
    return (addr % size) != 0;
  endfunction

  // Memory: rvalid arrives mem_lat cycles after the first ren cycle; stray rvalids otherwise.
  initial begin
    int age;
    age = 0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (dmem_ren) begin
        if (age == mem_lat) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_word;
        end else begin
          dmem_rvalid = 1'b0;
          dmem_rdata  = $urandom;
        end
        age++;
      end else begin
        age = 0;
        dmem_rvalid = ($urandom_range(0, 3) == 0);
        dmem_rdata  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a response or write strobe.
  initial begin
    logic   prev_ren;
    resp_t  r;
    store_t s;
    prev_ren = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_ren = 1'b0;
        continue;
      end
      if (dmem_ren || dmem_wen != 2'b00)
        chk("ren_wen_exclusive", {31'd0, dmem_ren && (dmem_wen != 2'b00)}, 32'd0);
      if (dmem_ren && !prev_ren) seen_loads++;
      prev_ren = dmem_ren;
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp_valid", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
          chk("resp_rdata", resp_rdata, r.data);
          chk("resp_latency", cyc - r.acc + 1, r.lat);
        end
      end
      if (dmem_wen != 2'b00) begin
        if (sq.size() == 0) begin
          chk("unexpected_dmem_wen", {30'd0, dmem_wen}, 32'd0);
        end else begin
          s = sq.pop_front();
          chk("store_wen", {30'd0, dmem_wen}, {30'd0, s.wen});
          chk("store_addr", dmem_addr, s.addr);
          chk("store_wdata", dmem_wdata, s.wdata);
          chk("store_latency", cyc - s.acc + 1, 1);
        end
      end
    end
  end

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic [31:0] word);
    resp_t  r;
    store_t s;
    int     guard;
    int     size;
    int     acc;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!req_ready && guard < 200);
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc  = cyc + 1;
    size = 1 << f3[1:0];
    if (is_err(f3, addr)) begin
      r.err = 1'b1; r.data = '0; r.acc = acc; r.lat = 1;
      rq.push_back(r);
    end else if (st) begin
      s.wen   = (size == 1) ? 2'b01 : (size == 2) ? 2'b10 : 2'b11;
      s.addr  = addr;
      s.wdata = wdata;
      s.acc   = acc;
      sq.push_back(s);
    end else begin
      exp_loads++;
      r.acc = acc;
      if (lat < TIMEOUT) begin
        r.err = 1'b0; r.data = ref_ext(f3, word); r.lat = lat + 2;
      end else begin
        r.err = 1'b1; r.data = '0; r.lat = TIMEOUT + 1;
      end
      rq.push_back(r);
    end
    @(posedge clock);
    #1;
    mem_lat    = lat;
    mem_word   = word;
    req_valid  = 1'b0;
    req_store  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  initial begin
    int          guard;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          lat;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_dmem_ren", {31'd0, dmem_ren}, 32'd0);
    chk("reset_dmem_wen", {30'd0, dmem_wen}, 32'd0);
    chk("reset_dmem_addr", dmem_addr, 32'd0);
    chk("reset_dmem_wdata", dmem_wdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    issue(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'h8000_00FF);
    issue(1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h1234_5680);
    issue(1'b0, 3'b100, 32'h101, 32'h0, 1, 32'h1234_5680);
    issue(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, NEVER, 32'h0);
    issue(1'b0, 3'b010, 32'h103, 32'h0, 0, 32'hDEAD_BEEF);
    issue(1'b1, 3'b010, 32'h102, 32'h5555_AAAA, 0, 32'h0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    issue(1'b0, 3'b001, 32'h100, 32'h0, NEVER, 32'h0);
    issue(1'b0, 3'b001, 32'h100, 32'h0, TIMEOUT - 1, 32'h0000_8001);
    issue(1'b0, 3'b101, 32'h102, 32'h0, TIMEOUT, 32'h0000_8001);
    issue(1'b0, 3'b101, 32'h106, 32'h0, 2, 32'h0000_8001);

    // Reset in the middle of a load drops it and returns the port to idle at once.
    issue(1'b0, 3'b010, 32'h100, 32'h0, NEVER, 32'h0);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_dmem_ren", {31'd0, dmem_ren}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    rq.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
      else lat = $urandom_range(0, 4);
      issue($urandom_range(0, 1) == 1, f3, addr, $urandom, lat, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    guard = 0;
    while ((rq.size() != 0 || sq.size() != 0) && guard < 300) begin
      @(posedge clock);
      guard++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("drain_resp_queue", rq.size(), 32'd0);
    chk("drain_store_queue", sq.size(), 32'd0);
    chk("load_strobe_count", seen_loads, exp_loads);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
